// File: rtl/fb_write_packer.sv
//==============================================================================
// Module      : fb_write_packer
// Description : Packs a pixel stream into 4-pixel, 128-bit DDR3 write requests
//               and buffers them in a small FIFO toward the memory arbiter.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module fb_write_packer #(
    parameter int WIDTH      = 640,
    parameter int HEIGHT     = 480,
    parameter int COLOR_BITS = 18,
    parameter int DEPTH      = 4
) (
    input  logic                       clk_x1,
    input  logic                       ddr_rst,
    input  logic [10:0]                fb_width,
    input  logic [9:0]                 fb_height,
    input  logic                       fb_vsync,
    input  logic                       fb_we,
    input  logic [COLOR_BITS-1:0]      fb_data,
    output logic                       wr_valid,
    input  logic                       wr_ready,
    output logic [27:0]                wr_addr,
    output logic [127:0]               wr_data,
    output logic                       overflow,
    output logic [$clog2(DEPTH):0]     fifo_level
);

    localparam int                c_ptr_w  = $clog2(DEPTH);
    localparam logic [c_ptr_w:0]  c_depth  = (c_ptr_w + 1)'(DEPTH);
    localparam logic [10:0]       c_max_w  = 11'(WIDTH);
    localparam logic [9:0]        c_max_h  = 10'(HEIGHT);
    localparam logic [27:0]       c_pitch  = 28'(WIDTH);

    // ------------------------------------------------------------------
    // Pixel coordinates and accumulator
    // ------------------------------------------------------------------
    logic [10:0]           r_x;
    logic [9:0]            r_y;
    logic [COLOR_BITS-1:0] r_acc [4];

    logic [10:0]           w_x;
    logic [9:0]            w_y;
    logic [10:0]           w_width;
    logic [9:0]            w_height;
    logic                  w_last_px;
    logic                  w_last_row;
    logic                  w_done;
    logic [27:0]           w_chunk_addr;
    logic [127:0]          w_chunk_data;
    logic [COLOR_BITS-1:0] w_slot_val [4];

    // A vsync arriving with a pixel makes that pixel (0,0) of the new frame.
    assign w_x = fb_vsync ? 11'd0 : r_x;
    assign w_y = fb_vsync ? 10'd0 : r_y;

    // Out-of-range geometry is clamped so addresses never leave the pitch.
    assign w_width  = (fb_width  > c_max_w) ? c_max_w : fb_width;
    assign w_height = (fb_height > c_max_h) ? c_max_h : fb_height;

    assign w_last_px  = ({1'b0, w_x} + 12'd1) >= {1'b0, w_width};
    assign w_last_row = ({1'b0, w_y} + 11'd1) >= {1'b0, w_height};
    assign w_done     = fb_we && ((w_x[1:0] == 2'b11) || w_last_px);

    // The completing pixel shares its line and chunk base with slot 0.
    assign w_chunk_addr = ({18'd0, w_y} * c_pitch + {17'd0, w_x[10:2], 2'b00}) << 1;

    generate
        for (genvar i = 0; i < 4; i++) begin : g_slot
            assign w_slot_val[i] = (2'(i) <  w_x[1:0]) ? r_acc[i] :
                                   (2'(i) == w_x[1:0]) ? fb_data  :
                                   {COLOR_BITS{1'b0}};
            assign w_chunk_data[32*i +: 32] = {{(32-COLOR_BITS){1'b0}}, w_slot_val[i]};
        end
    endgenerate

    always_ff @(posedge clk_x1 or posedge ddr_rst) begin
        if (ddr_rst) begin
            r_x <= 11'd0;
            r_y <= 10'd0;
        end else if (fb_we) begin
            if (w_last_px) begin
                r_x <= 11'd0;
                r_y <= w_last_row ? 10'd0 : (w_y + 10'd1);
            end else begin
                r_x <= w_x + 11'd1;
                r_y <= w_y;
            end
        end else if (fb_vsync) begin
            r_x <= 11'd0;
            r_y <= 10'd0;
        end
    end

    always_ff @(posedge clk_x1 or posedge ddr_rst) begin
        if (ddr_rst) begin
            for (int i = 0; i < 4; i++) r_acc[i] <= '0;
        end else begin
            if (fb_vsync || w_done) begin
                for (int i = 0; i < 4; i++) r_acc[i] <= '0;
            end
            if (fb_we && !w_done) begin
                r_acc[w_x[1:0]] <= fb_data;
            end
        end
    end

    // ------------------------------------------------------------------
    // Write-request FIFO
    // ------------------------------------------------------------------
    logic [c_ptr_w:0] r_wptr;
    logic [c_ptr_w:0] r_rptr;
    logic             r_overflow;
    logic [27:0]      r_mem_addr [DEPTH];
    logic [127:0]     r_mem_data [DEPTH];

    logic [c_ptr_w:0] w_level;
    logic             w_full;
    logic             w_pop;
    logic             w_push;
    logic             w_drop;

    assign w_level = r_wptr - r_rptr;
    assign w_full  = (w_level == c_depth);
    assign w_pop   = wr_valid && wr_ready;
    // A pop in the same cycle frees the slot the new chunk lands in.
    assign w_push  = w_done && (!w_full || w_pop);
    assign w_drop  = w_done && w_full && !w_pop;

    always_ff @(posedge clk_x1) begin
        if (w_push) begin
            r_mem_addr[r_wptr[c_ptr_w-1:0]] <= w_chunk_addr;
            r_mem_data[r_wptr[c_ptr_w-1:0]] <= w_chunk_data;
        end
    end

    always_ff @(posedge clk_x1 or posedge ddr_rst) begin
        if (ddr_rst) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            if (w_drop) r_overflow <= 1'b1;
        end
    end

    // Head is gated so an empty FIFO presents zeros, not stale storage.
    assign wr_valid   = (w_level != '0);
    assign wr_addr    = wr_valid ? r_mem_addr[r_rptr[c_ptr_w-1:0]] : 28'd0;
    assign wr_data    = wr_valid ? r_mem_data[r_rptr[c_ptr_w-1:0]] : 128'd0;
    assign overflow   = r_overflow;
    assign fifo_level = w_level;

endmodule

`default_nettype wire

// File: doc/fb_write_packer.md
FB_WRITE_PACKER -- requirements
Module: fb_write_packer

Interface
REQ-001 SHALL have parameter WIDTH, default 640; the framebuffer line pitch in pixels, a multiple of 4.
REQ-002 SHALL have parameter HEIGHT, default 480; the maximum framebuffer height.
REQ-003 SHALL have parameter COLOR_BITS, default 18; pixel width, range 12..24.
REQ-004 SHALL have parameter DEPTH, default 4; write-request FIFO entries, a power of 2 and at least 2.
REQ-005 SHALL have port clk_x1 input 1: the single clock (74.25 MHz pixel/controller clock).
REQ-006 SHALL have port ddr_rst input 1: reset, asynchronous and active-high.
REQ-007 SHALL have port fb_width input 11: active width in pixels, at most WIDTH.
REQ-008 SHALL have port fb_height input 10: active height in lines, at most HEIGHT.
REQ-009 SHALL have port fb_vsync input 1: one-cycle frame-start strobe.
REQ-010 SHALL have port fb_we input 1: pixel strobe; pixel accepted this cycle.
REQ-011 SHALL have port fb_data input COLOR_BITS: pixel value.
REQ-012 SHALL have port wr_valid output 1: the FIFO head holds a write request.
REQ-013 SHALL have port wr_ready input 1: the arbiter consumes the head this cycle.
REQ-014 SHALL have port wr_addr output 28: 16-bit-word DDR3 address of the request.
REQ-015 SHALL have port wr_data output 128: four packed pixels.
REQ-016 SHALL have port overflow output 1: sticky flag, set when a request was dropped.
REQ-017 SHALL have port fifo_level output $clog2(DEPTH)+1: current occupancy.

Function
REQ-018 SHALL hold x (11b) and y (10b) counters; each accepted pixel increments x.
REQ-019 SHALL, when x+1 >= fb_width, set x to 0 and increment y; when y+1 >= fb_height, set y to 0.
REQ-020 SHALL store the pixel in slot x[1:0] of a 4-slot accumulator.
REQ-021 SHALL complete a chunk when x[1:0]==3 or when the pixel is the last of its line.
REQ-022 SHALL zero the unwritten slots of a partial end-of-line chunk.
REQ-023 SHALL compute wr_addr = 2*(y*WIDTH + {x[10:2],2'b00}), zero-extended to 28 bits, using the coordinates of the chunk's first slot.
REQ-024 SHALL pack pixel i into wr_data[32*i +: COLOR_BITS] and set bits [32*i+COLOR_BITS +: 32-COLOR_BITS] to 0.
REQ-025 SHALL push each completed chunk into the FIFO at the completing clock edge.
REQ-026 SHALL assert wr_valid in the cycle after the push (1-cycle latency) when the FIFO was empty.
REQ-027 SHALL keep wr_addr and wr_data driven from the FIFO head and hold them stable while wr_valid=1 and wr_ready=0.
REQ-028 SHALL pop the head only on wr_valid && wr_ready; wr_ready while wr_valid=0 SHALL be ignored.
REQ-029 SHALL accept a push while full if a pop occurs in the same cycle; fifo_level is then unchanged.
REQ-030 SHALL, on a push while full with no pop, drop the new chunk, leave the FIFO unchanged and set overflow.
REQ-031 SHALL, on fb_vsync, reset x and y to 0 and discard the partial accumulator; FIFO contents are kept.
REQ-032 SHALL, when fb_vsync and fb_we occur in the same cycle, accept the pixel as pixel (0,0) of the new frame, leaving x=1 and y=0.
REQ-033 SHALL treat a change of fb_width or fb_height as effective immediately from the next comparison.

Reset
REQ-034 SHALL, while ddr_rst=1, asynchronously clear x, y, the accumulator, FIFO pointers and overflow; wr_valid=0, fifo_level=0, wr_addr=0, wr_data=0.
REQ-035 SHALL, on ddr_rst asserted mid-chunk or with a non-empty FIFO, discard all pending data; the first pixel after release is (0,0).
REQ-036 SHALL keep overflow at 1 once set, until ddr_rst.

Verification
REQ-037 SHALL pass this scenario: fb_width=640, vsync, then 4 pixels 1,2,3,4 with wr_ready=1 -> a single request with wr_addr=0 and wr_data=0x00000004_00000003_00000002_00000001, asserting wr_valid 1 cycle after the 4th pixel.
REQ-038 SHALL pass this scenario: 644 pixels at WIDTH=640 -> the 161st request has wr_addr=1280 (line 1, x=0).
REQ-039 SHALL pass this scenario: fb_width=6, 6 pixels -> a request at addr 0, then a partial request at addr 8 with slots 2 and 3 zero.
REQ-040 SHALL pass this scenario: wr_ready=0, DEPTH=4, 20 pixels -> fifo_level=4 and overflow=1, with head addr 0 still held; then wr_ready=1 -> exactly 4 requests drain.
REQ-041 SHALL pass this scenario: 2 pixels, then vsync together with fb_we of value A -> the next request has addr 0 with slot 0 = A.
REQ-042 SHALL pass this scenario: ddr_rst pulse with 3 entries queued -> wr_valid=0 and fifo_level=0 immediately, and overflow cleared.
